// File: rtl/ysyx_fetch_redirect.sv
// Front-end PC sequencer: issues fetch PCs, bounds in-flight instructions, tags fetches with an epoch
// and pulses flush on every writeback redirect. Define YSYX_FETCH_REDIRECT_STATS_EN for stat_* counters.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_fetch_redirect #(
    parameter int              XLEN         = `YSYX_XLEN,
    parameter logic [XLEN-1:0] RESET_PC     = 'h8000_0000,
    parameter int              MAX_INFLIGHT = 4,
    parameter int              EPOCH_W      = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [XLEN-1:0]    wb_npc,
    input  logic               wb_change,
    input  logic               wb_retire,
    input  logic               wb_valid,
    output logic               wb_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [EPOCH_W-1:0] if_epoch,
    output logic               if_valid,
    input  logic               if_ready,
    output logic               flush,
`ifdef YSYX_FETCH_REDIRECT_STATS_EN
    output logic [31:0]        stat_fetch,
    output logic [31:0]        stat_redirect,
    output logic [31:0]        stat_retire,
`endif
    output logic [3:0]         inflight
);

    typedef enum logic [1:0] {S_FLUSH, S_RUN, S_STALL} state_t;

    localparam logic [3:0]         MAX_CNT   = 4'(MAX_INFLIGHT);
    localparam logic [XLEN-1:0]    PC_STEP   = XLEN'(4);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [XLEN-1:0]    r_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic [3:0]         r_inflight;
    logic [3:0]         w_inflight_nxt;
    logic               r_flush;

    logic w_accept;
    logic w_redirect;
    logic w_wb_done;
    logic w_fetch;
    logic [1:0] w_unused_npc_lsb;

    assign w_accept   = if_valid & if_ready;
    assign w_redirect = wb_valid & wb_change;
    assign w_wb_done  = wb_valid & ~wb_change;
    // A redirect in the same cycle squashes the accepted fetch entirely.
    assign w_fetch    = w_accept & ~w_redirect;
    assign w_unused_npc_lsb = wb_npc[1:0];

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_redirect) begin
            w_inflight_nxt = 4'd0;
        end else if (w_fetch && !w_wb_done) begin
            w_inflight_nxt = r_inflight + 4'd1;
        end else if (!w_fetch && w_wb_done && (r_inflight != 4'd0)) begin
            w_inflight_nxt = r_inflight - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_FLUSH: w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = (w_inflight_nxt >= MAX_CNT) ? S_STALL : S_RUN;
                S_STALL: w_state_nxt = (w_inflight_nxt < MAX_CNT) ? S_RUN : S_STALL;
                default: w_state_nxt = S_FLUSH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_epoch    <= '0;
            r_inflight <= 4'd0;
            r_flush    <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_flush    <= w_redirect;
            if (w_redirect) begin
                r_pc    <= {wb_npc[XLEN-1:2], 2'b00};
                r_epoch <= r_epoch + EPOCH_ONE;
            end else if (w_fetch) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

`ifdef YSYX_FETCH_REDIRECT_STATS_EN
    logic [31:0] r_stat_fetch;
    logic [31:0] r_stat_redirect;
    logic [31:0] r_stat_retire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_fetch    <= 32'd0;
            r_stat_redirect <= 32'd0;
            r_stat_retire   <= 32'd0;
        end else begin
            if (w_fetch)                r_stat_fetch    <= r_stat_fetch + 32'd1;
            if (w_redirect)             r_stat_redirect <= r_stat_redirect + 32'd1;
            if (w_wb_done && wb_retire) r_stat_retire   <= r_stat_retire + 32'd1;
        end
    end

    assign stat_fetch    = r_stat_fetch;
    assign stat_redirect = r_stat_redirect;
    assign stat_retire   = r_stat_retire;
`else
    logic w_unused_retire;
    assign w_unused_retire = wb_retire;
`endif

    assign wb_ready = 1'b1;
    assign if_pc    = r_pc;
    assign if_epoch = r_epoch;
    assign if_valid = (r_state == S_RUN);
    assign flush    = r_flush;
    assign inflight = r_inflight;

endmodule

// File: tb/tb_ysyx_fetch_redirect.sv
// Self-checking bench for ysyx_fetch_redirect: directed literal scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_ysyx_fetch_redirect;

    localparam int MAXF = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] wb_npc = '0;
    logic        wb_change = 1'b0;
    logic        wb_retire = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [31:0] if_pc;
    logic [1:0]  if_epoch;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic        flush;
    logic [3:0]  inflight;
`ifdef YSYX_FETCH_REDIRECT_STATS_EN
    logic [31:0] stat_fetch, stat_redirect, stat_retire;
`endif

    ysyx_fetch_redirect dut (
        .clock(clock), .reset(reset),
        .wb_npc(wb_npc), .wb_change(wb_change), .wb_retire(wb_retire), .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .if_pc(if_pc), .if_epoch(if_epoch), .if_valid(if_valid), .if_ready(if_ready),
        .flush(flush),
`ifdef YSYX_FETCH_REDIRECT_STATS_EN
        .stat_fetch(stat_fetch), .stat_redirect(stat_redirect), .stat_retire(stat_retire),
`endif
        .inflight(inflight)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a fetch slot is offered unless a bubble follows a reset/redirect
    // or the in-flight budget is exhausted.
    logic [31:0] m_pc = 32'h8000_0000;
    int          m_epoch = 0;
    int          m_inflight = 0;
    bit          m_bubble = 1'b1;
    bit          m_flush = 1'b0;
    int unsigned m_sfetch = 0, m_sredir = 0, m_sretire = 0;

    function automatic bit m_valid();
        return !m_bubble && (m_inflight < MAXF);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc = 32'h8000_0000; m_epoch = 0; m_inflight = 0;
            m_bubble = 1'b1; m_flush = 1'b0;
            m_sfetch = 0; m_sredir = 0; m_sretire = 0;
        end else begin
            bit acc, redir, done;
            int n;
            acc   = m_valid() && if_ready;
            redir = wb_valid && wb_change;
            done  = wb_valid && !wb_change;
            if (redir) begin
                m_pc = wb_npc & 32'hFFFF_FFFC;
                m_epoch = (m_epoch + 1) % 4;
                m_inflight = 0;
                m_bubble = 1'b1;
                m_flush = 1'b1;
                m_sredir++;
            end else begin
                m_bubble = 1'b0;
                m_flush = 1'b0;
                if (acc) begin
                    m_pc = m_pc + 32'd4;
                    m_sfetch++;
                end
                n = m_inflight + (acc ? 1 : 0) - (done ? 1 : 0);
                m_inflight = (n < 0) ? 0 : n;
                if (done && wb_retire) m_sretire++;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("wb_ready", 32'(wb_ready), 32'd1);
            chk("if_valid", 32'(if_valid), 32'(m_valid()));
            chk("flush", 32'(flush), 32'(m_flush));
            chk("inflight", 32'(inflight), 32'(m_inflight));
            if (m_valid()) begin
                chk("if_pc", if_pc, m_pc);
                chk("if_epoch", 32'(if_epoch), 32'(m_epoch));
            end
`ifdef YSYX_FETCH_REDIRECT_STATS_EN
            chk("stat_fetch", stat_fetch, m_sfetch);
            chk("stat_redirect", stat_redirect, m_sredir);
            chk("stat_retire", stat_retire, m_sretire);
`endif
        end
    end

    initial begin
        reset = 1'b0;
        if_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        chk("rst if_valid", 32'(if_valid), 32'd0);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst inflight", 32'(inflight), 32'd0);
        chk("rst epoch", 32'(if_epoch), 32'd0);
        reset = 1'b1;

        // Straight-line fetch until the in-flight budget stalls.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("seq valid", 32'(if_valid), 32'd1);
            chk("seq pc", if_pc, 32'h8000_0000 + 32'(4 * i));
            chk("seq inflight", 32'(inflight), 32'(i));
        end
        @(negedge clock);
        chk("stall valid", 32'(if_valid), 32'd0);
        chk("stall inflight", 32'(inflight), 32'd4);
        wb_valid = 1'b1; wb_change = 1'b0;
        @(negedge clock);
        chk("unstall valid", 32'(if_valid), 32'd1);
        chk("unstall pc", if_pc, 32'h8000_0010);
        chk("unstall inflight", 32'(inflight), 32'd3);

        // Redirect in the same cycle as an accepted fetch.
        wb_valid = 1'b1; wb_change = 1'b1; wb_npc = 32'h8000_0103;
        @(negedge clock);
        wb_valid = 1'b0; wb_change = 1'b0;
        chk("redir flush", 32'(flush), 32'd1);
        chk("redir valid", 32'(if_valid), 32'd0);
        chk("redir inflight", 32'(inflight), 32'd0);
        chk("redir epoch", 32'(if_epoch), 32'd1);
        @(negedge clock);
        chk("redir flush drop", 32'(flush), 32'd0);
        chk("redir new valid", 32'(if_valid), 32'd1);
        chk("redir new pc", if_pc, 32'h8000_0100);

        // Four redirects spaced 3 cycles apart; epoch wraps.
        for (int k = 0; k < 4; k++) begin
            wb_valid = 1'b1; wb_change = 1'b1; wb_npc = $urandom;
            @(negedge clock);
            wb_valid = 1'b0; wb_change = 1'b0;
            chk("burst flush", 32'(flush), 32'd1);
            chk("burst epoch", 32'(if_epoch), 32'((2 + k) % 4));
            @(negedge clock);
            chk("burst flush once", 32'(flush), 32'd0);
            @(negedge clock);
        end

        // Asynchronous reset while stalled.
        repeat (6) @(negedge clock);
        chk("pre-reset inflight", 32'(inflight), 32'd4);
        #2 reset = 1'b0;
        #1;
        chk("async valid", 32'(if_valid), 32'd0);
        chk("async inflight", 32'(inflight), 32'd0);
        chk("async flush", 32'(flush), 32'd0);
        chk("async pc", if_pc, 32'h8000_0000);
        chk("async epoch", 32'(if_epoch), 32'd0);
`ifdef YSYX_FETCH_REDIRECT_STATS_EN
        chk("async stat_fetch", stat_fetch, 32'd0);
        chk("async stat_redirect", stat_redirect, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("restart pc", if_pc, 32'h8000_0000);
        chk("restart valid", 32'(if_valid), 32'd1);

        // Randomized traffic, including writebacks with nothing in flight and one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            wb_valid  = ($urandom_range(0, 99) < 35);
            wb_change = ($urandom_range(0, 99) < 15);
            wb_retire = $urandom_range(0, 1);
            wb_npc    = $urandom;
            if_ready  = ($urandom_range(0, 99) < 70);
            if (i == 1500) begin
                #2 reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        wb_valid = 1'b0;
        @(negedge clock);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
